// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the round-robin counter scheduler.
// Optional feature macro: COUNTER_SCHED_STATS_EN (per-requester grant counters).
package counter_sched_pkg;

   typedef enum logic [1:0] {
      OP_INIT  = 2'd0,
      OP_START = 2'd1,
      OP_READ  = 2'd2,
      OP_STAT  = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam int unsigned RESP_W = 64;
   // Returned for STAT when grant counters are not built in.
   localparam logic [RESP_W-1:0] RESP_UNSUP = '1;

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  idx_o,
   output logic            any_o
);

   int unsigned k;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      k     = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         k = (32'(ptr_i) + i) % NREQ;
         if (!any_o && req_i[k[IDW-1:0]]) begin
            any_o              = 1'b1;
            gnt_o[k[IDW-1:0]]  = 1'b1;
            idx_o              = k[IDW-1:0];
         end
      end
   end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one counter among NREQ requesters, one response per command.
// Optional feature macro: COUNTER_SCHED_STATS_EN (STAT returns per-requester grant count).
module counter_sched #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned NREQ    = 4,
   parameter int unsigned IDW     = 2,
   parameter int unsigned CTR_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [2*NREQ-1:0]    req_op,
   input  logic [XLEN*NREQ-1:0] req_data,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [IDW-1:0]       resp_id,
   output logic [XLEN-1:0]      resp_data,
   output logic                 ctr_init,
   output logic [XLEN-1:0]      ctr_init_val,
   output logic                 ctr_start,
   output logic                 ctr_return,
   input  logic [XLEN-1:0]      ctr_count
);

   import counter_sched_pkg::*;

   state_t          state_q, state_d;
   op_t             op_q, gnt_op;
   logic [IDW-1:0]  ptr_q, id_q, gnt_idx;
   logic [NREQ-1:0] gnt_oh;
   logic            gnt_any, take;
   logic [XLEN-1:0] gnt_data, ival_q, rdata_q, rdata_d, stat_val;
   logic            init_q, start_q, ret_q;
   logic [2:0]      wait_q;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (gnt_oh),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   assign take     = (state_q == ST_IDLE) && gnt_any;
   // Flops sit in IDLE during reset, so ready must also be masked by reset itself.
   assign req_ready = (take && reset) ? gnt_oh : '0;
   assign gnt_op   = op_t'(req_op[2*32'(gnt_idx) +: 2]);
   assign gnt_data = req_data[XLEN*32'(gnt_idx) +: XLEN];

`ifdef COUNTER_SCHED_STATS_EN
   logic [31:0] gcnt_q [NREQ];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NREQ; i++) gcnt_q[i] <= '0;
      end else if (take) begin
         gcnt_q[gnt_idx] <= gcnt_q[gnt_idx] + 32'd1;
      end
   end

   assign stat_val = XLEN'(gcnt_q[id_q]);
`else
   assign stat_val = XLEN'(RESP_UNSUP);
`endif

   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      unique case (state_q)
         ST_IDLE:  if (gnt_any) state_d = ST_ISSUE;
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (wait_q <= 3'd1) begin
               state_d = ST_RESP;
               unique case (op_q)
                  OP_READ: rdata_d = ctr_count;
                  OP_STAT: rdata_d = stat_val;
                  default: rdata_d = '0;
               endcase
            end
         end
         ST_RESP:  if (resp_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         op_q    <= OP_INIT;
         ptr_q   <= '0;
         id_q    <= '0;
         ival_q  <= '0;
         rdata_q <= '0;
         init_q  <= 1'b0;
         start_q <= 1'b0;
         ret_q   <= 1'b0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         init_q  <= take && (gnt_op == OP_INIT);
         start_q <= take && (gnt_op == OP_START);
         ret_q   <= take && (gnt_op == OP_READ);
         if (take) begin
            op_q  <= gnt_op;
            id_q  <= gnt_idx;
            ptr_q <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
            if (gnt_op == OP_INIT) ival_q <= gnt_data;
         end
         if (state_q == ST_ISSUE)
            wait_q <= 3'(CTR_LAT);
         else if (state_q == ST_WAIT && wait_q != 3'd0)
            wait_q <= wait_q - 3'd1;
      end
   end

   assign resp_valid   = (state_q == ST_RESP);
   assign resp_id      = id_q;
   assign resp_data    = rdata_q;
   assign ctr_init     = init_q;
   assign ctr_init_val = ival_q;
   assign ctr_start    = start_q;
   assign ctr_return   = ret_q;

endmodule

// File: tb/tb_counter_sched.sv
// Directed, table-driven bench for counter_sched with a simple counter model (CTR_LAT=1).
module tb_counter_sched;

   localparam int NREQ = 4;
   localparam int XLEN = 64;

   logic              clk;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [2*NREQ-1:0] req_op;
   logic [XLEN*NREQ-1:0] req_data;
   logic              resp_valid;
   logic              resp_ready;
   logic [1:0]        resp_id;
   logic [XLEN-1:0]   resp_data;
   logic              ctr_init;
   logic [XLEN-1:0]   ctr_init_val;
   logic              ctr_start;
   logic              ctr_return;
   logic [XLEN-1:0]   ctr_count;

   counter_sched #(.XLEN(XLEN), .NREQ(NREQ), .IDW(2), .CTR_LAT(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_data     (req_data),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_id      (resp_id),
      .resp_data    (resp_data),
      .ctr_init     (ctr_init),
      .ctr_init_val (ctr_init_val),
      .ctr_start    (ctr_start),
      .ctr_return   (ctr_return),
      .ctr_count    (ctr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int n_init = 0, n_start = 0, n_ret = 0, n_ovl = 0;
   logic [63:0] cnt = '0, exp_read = '0;
   logic        run = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Counter model and pulse monitor; pulses are full-cycle, so sample mid-cycle.
   always @(negedge clk) begin
      if (!reset) begin
         cnt <= '0; run <= 1'b0; ctr_count <= '0;
      end else begin
         n_init  <= n_init  + int'(ctr_init);
         n_start <= n_start + int'(ctr_start);
         n_ret   <= n_ret   + int'(ctr_return);
         if (int'(ctr_init) + int'(ctr_start) + int'(ctr_return) > 1) n_ovl <= n_ovl + 1;
         if (ctr_init) begin
            cnt <= ctr_init_val; run <= 1'b0;
         end else if (ctr_start) begin
            run <= 1'b1;
         end else if (run) begin
            cnt <= cnt + 64'd1;
         end
         if (ctr_return) begin
            ctr_count <= cnt; exp_read <= cnt;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0; req_valid = '0; resp_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the grant edge.
   task automatic send(input int r, input logic [1:0] op, input logic [63:0] d, output bit ok);
      ok = 1'b0;
      req_op[2*r +: 2]     = op;
      req_data[64*r +: 64] = d;
      req_valid[r]         = 1'b1;
      for (int n = 0; n < 50; n++) begin
         #1;
         if (req_ready[r]) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      @(negedge clk);
      req_valid[r] = 1'b0;
   endtask

   task automatic get_resp(output logic [1:0] id, output logic [63:0] d, output bit ok);
      ok = 1'b0; id = '0; d = '0;
      for (int n = 0; n < 50; n++) begin
         #1;
         if (resp_valid) begin ok = 1'b1; id = resp_id; d = resp_data; break; end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   typedef struct {
      int          r;
      logic [1:0]  op;
      logic [63:0] d;
      int          gap;
      logic [63:0] exp_data;
      bit          use_model;
      logic [2:0]  exp_pulse;   // {init, start, return}
      logic [63:0] exp_ival;
   } vec_t;

   vec_t vt [6];

   initial begin
      bit ok;
      logic [1:0]  id, id0;
      logic [63:0] d, d0, exp_stat;
      int pi, ps, pr, tg, prev_tg, gidx, lat;
      bit stable, quiet;

      vt[0] = '{0, 2'd0, 64'd75,          0,  64'd0, 1'b0, 3'b100, 64'd75};
      vt[1] = '{0, 2'd1, 64'd0,           0,  64'd0, 1'b0, 3'b010, 64'd75};
      vt[2] = '{0, 2'd2, 64'd0,           20, 64'd0, 1'b1, 3'b001, 64'd75};
      vt[3] = '{3, 2'd0, 64'hDEAD_BEEF,   0,  64'd0, 1'b0, 3'b100, 64'hDEAD_BEEF};
      vt[4] = '{2, 2'd2, 64'd0,           3,  64'd0, 1'b1, 3'b001, 64'hDEAD_BEEF};
      vt[5] = '{1, 2'd1, 64'd0,           0,  64'd0, 1'b0, 3'b010, 64'hDEAD_BEEF};

      reset = 1'b0; req_valid = '1; req_op = '0; req_data = '0; resp_ready = 1'b1;

      // 1. reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_ctr_pulses", 64'({ctr_init, ctr_start, ctr_return}), 64'd0);
      chk("rst_init_val", ctr_init_val, 64'd0);
      chk("rst_resp", {resp_data[61:0], resp_id}, 64'd0);
      do_reset();

      // 2. table of single commands
      for (int i = 0; i < 6; i++) begin
         repeat (vt[i].gap) @(negedge clk);
         pi = n_init; ps = n_start; pr = n_ret;
         send(vt[i].r, vt[i].op, vt[i].d, ok);
         chk($sformatf("v%0d_grant", i), 64'(ok), 64'd1);
         get_resp(id, d, ok);
         chk($sformatf("v%0d_resp_seen", i), 64'(ok), 64'd1);
         chk($sformatf("v%0d_id", i), 64'(id), 64'(vt[i].r));
         chk($sformatf("v%0d_data", i), d, vt[i].use_model ? exp_read : vt[i].exp_data);
         chk($sformatf("v%0d_pulses", i),
             64'({(n_init - pi) == 1, (n_start - ps) == 1, (n_ret - pr) == 1}) |
             64'({(n_init - pi) > 1, (n_start - ps) > 1, (n_ret - pr) > 1}) << 3,
             64'(vt[i].exp_pulse));
         chk($sformatf("v%0d_init_val", i), ctr_init_val, vt[i].exp_ival);
         if (i == 2) chk("v2_counted", 64'(d > 64'd95), 64'd1);
      end

      // 3. all four READ: order 0,1,2,3,0, 4-cycle spacing, response 3 negedges after grant
      do_reset();
      req_op = {4{2'd2}}; req_valid = '1; prev_tg = 0;
      for (int g = 0; g < 5; g++) begin
         ok = 1'b0;
         for (int n = 0; n < 20; n++) begin
            #1;
            if (req_ready != '0) begin ok = 1'b1; break; end
            @(negedge clk);
         end
         chk($sformatf("rr%0d_grant", g), 64'(ok), 64'd1);
         tg = cyc; gidx = -1;
         for (int b = 0; b < NREQ; b++) if (req_ready[b]) gidx = b;
         chk($sformatf("rr%0d_order", g), 64'(gidx), 64'(g % 4));
         if (g > 0) chk($sformatf("rr%0d_spacing", g), 64'(tg - prev_tg), 64'd4);
         prev_tg = tg;
         for (lat = 1; lat < 20; lat++) begin
            @(negedge clk);
            if (lat == 1 && g == 4) req_valid = '0;
            #1;
            if (resp_valid) break;
         end
         chk($sformatf("rr%0d_latency", g), 64'(lat), 64'd3);
         chk($sformatf("rr%0d_resp_id", g), 64'(resp_id), 64'(g % 4));
         @(negedge clk);
      end

      // 4. backpressure: response held stable, no new grant
      do_reset();
      resp_ready = 1'b0;
      send(1, 2'd2, 64'd0, ok);
      req_op[1:0] = 2'd2; req_op[5:4] = 2'd2;
      req_valid[0] = 1'b1; req_valid[2] = 1'b1;
      get_resp(id0, d0, ok);
      chk("bp_resp_seen", 64'(ok), 64'd1);
      chk("bp_id", 64'(id0), 64'd1);
      stable = 1'b1;
      for (int n = 0; n < 10; n++) begin
         #1;
         if (!resp_valid || resp_id !== id0 || resp_data !== d0 || req_ready !== '0) stable = 1'b0;
         @(negedge clk);
      end
      chk("bp_stable", 64'(stable), 64'd1);
      resp_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("bp_valid_drop", 64'(resp_valid), 64'd0);
      chk("bp_next_grant", 64'(req_ready), 64'b0100);
      @(negedge clk);
      req_valid = '0;
      get_resp(id, d, ok);
      chk("bp_next_id", 64'(id), 64'd2);

      // 5. reset during WAIT aborts; rr_ptr returns to 0
      do_reset();
      send(2, 2'd2, 64'd0, ok);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_outputs", 64'({resp_valid, ctr_return, req_ready}), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      quiet = 1'b1;
      for (int n = 0; n < 6; n++) begin
         #1;
         if (resp_valid) quiet = 1'b0;
         @(negedge clk);
      end
      chk("abort_no_resp", 64'(quiet), 64'd1);
      req_op[5:4] = 2'd2; req_op[7:6] = 2'd2;
      req_valid[2] = 1'b1; req_valid[3] = 1'b1;
      #1;
      chk("abort_ptr0_grant", 64'(req_ready), 64'b0100);
      @(negedge clk);
      req_valid = '0;
      get_resp(id, d, ok);
      chk("abort_new_id", 64'(id), 64'd2);

      // 6. STAT after three grants to req1
      do_reset();
      for (int k = 0; k < 3; k++) begin
         send(1, 2'd0, 64'(k + 10), ok);
         get_resp(id, d, ok);
      end
      send(1, 2'd3, 64'd0, ok);
      get_resp(id, d, ok);
`ifdef COUNTER_SCHED_STATS_EN
      exp_stat = 64'd4;
`else
      exp_stat = '1;
`endif
      chk("stat_id", 64'(id), 64'd1);
      chk("stat_data", d, exp_stat);
      chk("no_pulse_overlap", 64'(n_ovl), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
